seg7_scan_driver: RTL

Multiplexed seven-segment display driver for the digital clock. It takes the clock's BCD digit vector, snapshots it once per frame and time-multiplexes it across NDIG common-anode displays. It derives its own per-digit slot strobe from clkM, so no divided clock is needed. It sits between the timekeeping counters and the board's anode and segment pins, with per-digit blanking to suppress ghosting.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_decode.sv | 12 +
 rtl/seg7_scan_driver.sv | 105 ++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
package seg7_pkg;

  // All segments off (active-low).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for 0..9; codes 10..15 show a dash.
  localparam logic [6:0] SEG7_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
  };

  // Number of clkM cycles in one digit slot.
  function automatic int slot_div(input int m, input int slot_hz);
    return m / slot_hz;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment lookup.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup; invalid codes are covered by the table itself.
  assign seg = SEG7_LUT[bcd];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment driver with per-frame snapshot,
// per-slot blanking and optional leading-zero suppression.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int M       = 10_000_000,
  parameter int SLOT_HZ = 500,
  parameter int NDIG    = 6,
  parameter int BLANK   = 1000
) (
  input  logic              clkM,
  input  logic              clr,
  input  logic [4*NDIG-1:0] digits,
  input  logic [NDIG-1:0]   dp_mask,
  input  logic              blank_lz,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              frame_start
);

  localparam int DIV = slot_div(M, SLOT_HZ);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [4*NDIG-1:0] snap_d;
  logic [NDIG-1:0]   snap_dp;

  logic              last_cnt;
  logic              last_idx;
  logic              frame_tick;
  logic [3:0]        cur_digit;
  logic              cur_dp;
  logic [NDIG-1:0]   an_lit;
  logic [6:0]        dec_seg;
  logic              lit;

  assign last_cnt   = (cnt == CW'(DIV - 1));
  assign last_idx   = (idx == IW'(NDIG - 1));
  assign frame_tick = (cnt == '0) && (idx == '0);

  // Slot counter and digit index; idx advances at the end of each slot.
  always_ff @(posedge clkM) begin
    if (!clr) begin
      cnt <= '0;
      idx <= '0;
    end else if (last_cnt) begin
      cnt <= '0;
      idx <= last_idx ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Capture the displayed value once per frame so a frame never mixes two times.
  always_ff @(posedge clkM) begin
    if (!clr) begin
      snap_d  <= '0;
      snap_dp <= '0;
    end else if (frame_tick) begin
      snap_d  <= digits;
      snap_dp <= dp_mask;
    end
  end

  // Select the current digit from the snapshot and build its one-cold anode word.
  always_comb begin
    cur_digit = 4'd0;
    cur_dp    = 1'b0;
    an_lit    = '1;
    for (int k = 0; k < NDIG; k++) begin
      if (idx == IW'(k)) begin
        cur_digit = snap_d[4*k +: 4];
        cur_dp    = snap_dp[k];
        an_lit[k] = 1'b0;
      end
    end
  end

  seg7_decode u_decode (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // Lit only after the blanking window, unless this is a suppressed leading zero.
  assign lit = (cnt >= CW'(BLANK)) && !(blank_lz && last_idx && (cur_digit == 4'd0));

  // Registered pin drivers; everything is dark while not lit.
  always_ff @(posedge clkM) begin
    if (!clr) begin
      an          <= '1;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      an          <= lit ? an_lit  : '1;
      seg         <= lit ? dec_seg : SEG_OFF;
      dp          <= lit ? ~cur_dp : 1'b1;
      frame_start <= frame_tick;
    end
  end

endmodule
